// File: rtl/msr_pkg.sv
// msr_pkg: shared types for the msr_seq shift/rotate sequencer.
//   msr_mode_e  : 3-bit operation code presented on the mode port.
//   msr_state_e : sequencer FSM state, also visible on msr_seq.dbg_state.
//   is_stepped(): true for the modes that move bits one step per clock.
package msr_pkg;

  typedef enum logic [2:0] {
    MODE_NOP   = 3'd0,
    MODE_LOAD  = 3'd1,
    MODE_CLEAR = 3'd2,
    MODE_ROR   = 3'd3,
    MODE_ROL   = 3'd4,
    MODE_SHR   = 3'd5,
    MODE_SHL   = 3'd6,
    MODE_ASR   = 3'd7
  } msr_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } msr_state_e;

  // ROR..ASR are the only modes that take more than the accepting edge.
  function automatic logic is_stepped(input msr_mode_e m);
    return (m == MODE_ROR) || (m == MODE_ROL) || (m == MODE_SHR) ||
           (m == MODE_SHL) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/msr_step.sv
// msr_step: combinational single-step shift/rotate function.
//   q         in  WIDTH : current register contents
//   mode      in  3     : operation code (only ROR..ASR change q)
//   serial_in in  1     : fill bit for SHR/SHL
//   next_q    out WIDTH : register contents after one 1-bit step
//   out_bit   out 1     : bit leaving the register on this step
module msr_step
  import msr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  msr_mode_e        mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);

  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (mode)
      MODE_ROR: begin
        next_q  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ROL: begin
        next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      MODE_SHR: begin
        next_q  = {serial_in, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_SHL: begin
        next_q  = {q[WIDTH-2:0], serial_in};
        out_bit = q[WIDTH-1];
      end
      MODE_ASR: begin
        next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        next_q  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/msr_seq.sv
// msr_seq: multi-mode shift/rotate register with a step sequencer.
// One accepted command either completes on the accepting edge (NOP, LOAD,
// CLEAR, or any effective amount of 0) or runs one 1-bit step per clock
// for min(amount, WIDTH) clocks.
//
// Handshake: start is sampled only while idle (busy low). An accepted
// stepped command raises busy from the next cycle until its last step;
// every accepted command ends with done high for exactly one cycle, and a
// new start may be presented in that done cycle. start during busy is
// dropped, not queued.
//
// Ports:
//   clk        in  1     : rising-edge clock
//   rst        in  1     : asynchronous active-high reset
//   start      in  1     : command request
//   mode       in  3     : operation code (msr_mode_e)
//   amount     in  CNT_W : step count, saturates at WIDTH
//   load_data  in  WIDTH : parallel load value
//   serial_in  in  1     : fill bit for SHR/SHL, sampled every step
//   q          out WIDTH : register contents
//   serial_out out 1     : last bit shifted/rotated out
//   busy       out 1     : stepped command in progress
//   done       out 1     : one-cycle completion pulse
//   dbg_state  out 1     : current FSM state
module msr_seq
  import msr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output msr_state_e       dbg_state
);

  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  msr_state_e       state;
  msr_mode_e        mode_in;
  msr_mode_e        mode_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] amt_eff;
  logic             immediate;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  assign mode_in   = msr_mode_e'(mode);
  // More than WIDTH steps would only repeat work, so clamp the count.
  assign amt_eff   = (amount > WIDTH_CNT) ? WIDTH_CNT : amount;
  assign immediate = !is_stepped(mode_in) || (amt_eff == '0);
  assign dbg_state = state;

  // Steps use the latched mode so mode changes during RUN are ignored.
  msr_step #(.WIDTH(WIDTH)) u_step (
    .q         (q),
    .mode      (mode_r),
    .serial_in (serial_in),
    .next_q    (step_q),
    .out_bit   (step_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode_r     <= MODE_NOP;
      cnt        <= '0;
      q          <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (immediate) begin
              case (mode_in)
                MODE_LOAD:  q <= load_data;
                MODE_CLEAR: q <= '0;
                default:    q <= q;
              endcase
              done <= 1'b1;
            end else begin
              mode_r <= mode_in;
              cnt    <= amt_eff;
              busy   <= 1'b1;
              state  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          q          <= step_q;
          serial_out <= step_bit;
          cnt        <= cnt - ONE_CNT;
          if (cnt == ONE_CNT) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msr_seq.sv
// tb_msr_seq: directed-vector bench for msr_seq (WIDTH=8).
// The driver pushes the expected q/serial_out for every command into
// queues; the monitor pops and compares on every done pulse.
module tb_msr_seq;
  import msr_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] amount;
  logic [W-1:0]  load_data;
  logic          serial_in;
  logic [W-1:0]  q;
  logic          serial_out;
  logic          busy;
  logic          done;
  msr_state_e    dbg_state;

  logic [W-1:0] exp_q[$];
  logic         exp_so[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  msr_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .amount     (amount),
    .load_data  (load_data),
    .serial_in  (serial_in),
    .q          (q),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) check("busy_and_done", 32'd1, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          check("q", 32'(q), 32'(exp_q.pop_front()));
          check("serial_out", 32'(serial_out), 32'(exp_so.pop_front()));
        end
      end
    end
  end

  // Driver: call just after a negedge. Returns at the negedge of the done
  // cycle so the next call presents start in that cycle. poke_at >= 0
  // raises start with LOAD 0xFF during that busy cycle.
  task automatic run_cmd(input msr_mode_e m, input logic [CW-1:0] a,
                         input logic [W-1:0] d, input logic si,
                         input logic [W-1:0] eq, input logic eso,
                         input int ebusy, input int poke_at);
    int  nb;
    bit  seen;
    nb   = 0;
    seen = 0;
    exp_q.push_back(eq);
    exp_so.push_back(eso);
    mode      = m;
    amount    = a;
    load_data = d;
    serial_in = si;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nb++;
      if (busy && nb == poke_at) begin
        start     = 1'b1;
        mode      = MODE_LOAD;
        load_data = 8'hFF;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    check("busy_cycles", 32'(nb), 32'(ebusy));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 3'd0;
    amount    = '0;
    load_data = '0;
    serial_in = 1'b0;
    @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_serial_out", 32'(serial_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of ROR 5 on 0xA5 (serial_out is 1 by then).
    run_cmd(MODE_LOAD, 4'd0, 8'hA5, 1'b0, 8'hA5, 1'b0, 0, -1);
    mode   = MODE_ROR;
    amount = 4'd5;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_q", 32'(q), 32'd0);
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_serial_out", 32'(serial_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Post-reset load, then immediate cases (back-to-back on done).
    run_cmd(MODE_LOAD,  4'd0, 8'h3C, 1'b0, 8'h3C, 1'b0, 0, -1);
    run_cmd(MODE_ROR,   4'd0, 8'h00, 1'b0, 8'h3C, 1'b0, 0, -1);
    run_cmd(MODE_CLEAR, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0, -1);

    // Single-step and multi-step rotates and shifts.
    run_cmd(MODE_LOAD,  4'd0, 8'h81, 1'b0, 8'h81, 1'b0, 0, -1);
    run_cmd(MODE_ROR,   4'd1, 8'h00, 1'b0, 8'hC0, 1'b1, 1, -1);
    run_cmd(MODE_LOAD,  4'd0, 8'h81, 1'b0, 8'h81, 1'b1, 0, -1);
    run_cmd(MODE_ROL,   4'd3, 8'h00, 1'b0, 8'h0C, 1'b0, 3, -1);
    run_cmd(MODE_LOAD,  4'd0, 8'h90, 1'b0, 8'h90, 1'b0, 0, -1);
    run_cmd(MODE_ASR,   4'd3, 8'h00, 1'b0, 8'hF2, 1'b0, 3, -1);
    run_cmd(MODE_LOAD,  4'd0, 8'h90, 1'b0, 8'h90, 1'b0, 0, -1);
    run_cmd(MODE_SHR,   4'd3, 8'h00, 1'b0, 8'h12, 1'b0, 3, -1);
    run_cmd(MODE_LOAD,  4'd0, 8'h01, 1'b0, 8'h01, 1'b0, 0, -1);
    run_cmd(MODE_SHL,   4'd2, 8'h00, 1'b1, 8'h07, 1'b0, 2, -1);

    // SHR by WIDTH fills with serial_in; ROR 12 saturates to 8 steps.
    run_cmd(MODE_LOAD,  4'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0, -1);
    run_cmd(MODE_SHR,   4'd8, 8'h00, 1'b1, 8'hFF, 1'b0, 8, -1);
    run_cmd(MODE_LOAD,  4'd0, 8'h5A, 1'b0, 8'h5A, 1'b0, 0, -1);
    run_cmd(MODE_ROR,   4'd12, 8'h00, 1'b0, 8'h5A, 1'b0, 8, -1);

    // LOAD 0xFF started mid-RUN must be dropped.
    run_cmd(MODE_ROR,   4'd4, 8'h00, 1'b0, 8'hA5, 1'b1, 4, 2);

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
